icache_l1: RTL and testbench
============================

# icache_l1

Parametrised set-associative L1 instruction cache for the hart fetch stage. It sits between the fetch PC and the memory bus. It serves 32-bit instruction words on a hit in the same cycle and refills whole lines through a request/data-valid bus handshake. It generalises the earlier fixed-geometry cache with configurable sets, ways and line size, a registered miss FSM with a latched refill address, first-invalid-then-PLRU victim selection, sequential `fence.i` flush, and hit/miss counters.

## Interface
- `SETS`, default 64: number of sets; power of two, ≥2.
- `WAYS`, default 4: associativity; power of two, ≥1 (1 = direct mapped, PLRU logic absent).
- `LINE_BYTES`, default 32: line size in bytes; power of two, ≥4.
- Derived: OFFS=log2(LINE_BYTES), IDX=log2(SETS), TAG=64-IDX-OFFS.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `f_pc` in 64: fetch address; `f_pc[1:0]` is always 0.
- `f_req` in 1: fetch request.
- `f_ir` out 32: instruction word at `f_pc`.
- `f_vld` out 1: `f_ir` is valid this cycle.
- `flush` in 1: single-cycle `fence.i` pulse, invalidates the whole cache.
- `flush_busy` out 1: a flush is in progress or pending.
- `b_addr` out 64: line-aligned refill address, with low OFFS bits = 0.
- `b_rd` out 1: refill request, held until `b_dv`.
- `b_data` in LINE_BYTES*8: refill line; byte 0 is at bits [7:0].
- `b_dv` in 1: `b_data` is valid; accepted only in REFILL.
- `hit_cnt` out 32: count of hits, wraps.
- `miss_cnt` out 32: count of misses, wraps.

## Operation
- Address split: tag=`f_pc[63:64-TAG]`, index=`f_pc[IDX+OFFS-1:OFFS]`, offset=`f_pc[OFFS-1:0]`. `f_ir` = line bytes [offset +: 4].
- Hit condition: valid & tag match in any way of the indexed set. At most one way matches.
- FSM states:
  - IDLE
    - Hit with `f_req`: `f_vld`=1, PLRU updated, `hit_cnt`+1.
    - Miss with `f_req`: latch line address into `b_addr`, select victim, `miss_cnt`+1, go to REFILL.
    - `flush` (or pending flush): go to FLUSH; this takes priority over a miss in the same cycle.
  - REFILL
    - `b_rd`=1, `f_vld`=0.
    - On `b_dv`: write data, tag and valid=1 into the latched set/victim; mark the victim most-recently-used; go to IDLE, or to FLUSH if a flush is pending.
  - FLUSH
    - Clears the valid bits of one set per cycle, index 0..SETS-1; then returns to IDLE.
    - PLRU bits are cleared with their set.
- Victim selection:
  - Lowest-index invalid way first.
  - Otherwise tree-PLRU: WAYS-1 bits per set, heap order (root 0, children 2i+1/2i+2).
  - Node bit 0 means the victim lies in the left (lower) half.
  - On any access to way w, each node on w's path is set to point away from w.
- A refill is never cancelled. If `f_pc` changes during REFILL, the refill still completes for the latched address, and the new PC is looked up in IDLE.
- A `flush` pulse in REFILL or FLUSH sets a pending bit, cleared on FLUSH entry. `flush_busy` = pending | state==FLUSH.
- `b_dv` outside REFILL is ignored.

## Timing
- Reset values: state IDLE; all valid and PLRU bits 0; `f_vld`=0; `b_rd`=0; `b_addr`=0; `flush_busy`=0; counters 0.
- A `rst` asserted mid-refill or mid-flush aborts it. The in-flight `b_dv` in the next cycle is ignored.
- Hit latency is 0: `f_vld`/`f_ir` are combinational from `f_pc` in IDLE.
- Miss sequence:
  - Cycle t: miss detected, `f_vld`=0.
  - Cycle t+1: `b_rd`=1 with a valid `b_addr`.
  - First `b_dv` at cycle t+k (k≥1): line written at that edge.
  - Cycle t+k+1: IDLE, `b_rd`=0, hit.
  - Minimum miss-to-hit time is 2 cycles.
- Flush occupies exactly SETS cycles in FLUSH; the first post-flush lookup is in cycle SETS+1 after entry.
- `b_addr` is stable for the whole REFILL.

## Test plan
- After reset, `f_req`=1, `f_pc`=0x1000 → `f_vld`=0, `b_rd`=1 and `b_addr`=0x1000 next cycle. Then `b_dv` with word 0x00000013 at offset 0 → `f_vld`=1 and `f_ir`=0x00000013 one cycle later; `miss_cnt`=1, `hit_cnt`=1.
- Default geometry: fill 4 ways of set 0 (0x0000, 0x0800, 0x1000, 0x1800). Hit 0x0000, 0x1000, then miss 0x2000 → victim is way 1 (0x0800). Re-fetching 0x0800 misses, re-fetching 0x0000 hits.
- Hold `b_dv` low for 10 cycles during REFILL, changing `f_pc` each cycle → `b_addr` is unchanged, `f_vld`=0 throughout, and the line lands at the latched address.
- `flush` pulse during REFILL → the refill completes, then `flush_busy`=1 for exactly 64 cycles. Afterwards every previously resident line misses.
- `rst` one cycle after `b_rd` rises, with `b_dv` the following cycle → no line is valid, `b_rd`=0, and the counters read 0.
- Sweep WAYS=1/SETS=16/LINE_BYTES=4 and WAYS=8/LINE_BYTES=64 → offset selection and `b_addr` alignment are correct, and random traffic matches a reference model.

Source files
------------

// File: rtl/icache_l1.sv
// icache_l1: set-associative L1 instruction cache with line refill, fence.i flush and hit/miss counters
module icache_l1 #(
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             f_pc,
  input  logic                    f_req,
  output logic [31:0]             f_ir,
  output logic                    f_vld,
  input  logic                    flush,
  output logic                    flush_busy,
  output logic [63:0]             b_addr,
  output logic                    b_rd,
  input  logic [LINE_BYTES*8-1:0] b_data,
  input  logic                    b_dv,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);
  localparam int OFFS = $clog2(LINE_BYTES);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = 64 - IDX - OFFS;
  localparam int LW   = $clog2(WAYS);
  localparam int WB   = WAYS > 1 ? LW : 1;
  localparam int PB   = WAYS > 1 ? WAYS - 1 : 1;
  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;
  state_t state, state_n;
  logic [LINE_BYTES*8-1:0] data [SETS][WAYS];
  logic [TAG-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [PB-1:0] plru [SETS];
  logic [IDX-1:0] idx, ridx, fidx;
  logic [TAG-1:0] tag, rtag;
  logic [WB-1:0] hw, vic, rv;
  logic hit, pend;
  assign idx  = f_pc[IDX+OFFS-1:OFFS];
  assign tag  = f_pc[63:IDX+OFFS];
  assign ridx = b_addr[IDX+OFFS-1:OFFS];
  assign rtag = b_addr[63:IDX+OFFS];
  function automatic logic [WB-1:0] plru_victim(input logic [PB-1:0] t);
    int n, v;
    n = 0;
    v = 0;
    for (int l = 0; l < LW; l++) begin
      v = 2 * v + int'(t[n]);
      n = 2 * n + 1 + int'(t[n]);
    end
    return WB'(v);
  endfunction
  function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] t, input logic [WB-1:0] w);
    int n;
    n = 0;
    for (int l = LW - 1; l >= 0; l--) begin
      t[n] = ~w[l];
      n = 2 * n + 1 + int'(w[l]);
    end
    return t;
  endfunction
  always_comb begin
    hit = 1'b0;
    hw  = '0;
    vic = plru_victim(plru[idx]);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) vic = WB'(w);
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit = 1'b1;
        hw  = WB'(w);
      end
    end
  end
  always_comb begin
    state_n = state == IDLE   ? ((flush || pend) ? FLUSH : (f_req && !hit) ? REFILL : IDLE) :
              state == REFILL ? (b_dv ? ((flush || pend) ? FLUSH : IDLE) : REFILL) :
              (fidx == IDX'(SETS - 1) ? IDLE : FLUSH);
  end
  always_comb begin
    f_vld      = state == IDLE && f_req && hit && !flush && !pend;
    f_ir       = 32'(data[idx][hw] >> {f_pc[OFFS-1:0], 3'b000});
    b_rd       = state == REFILL;
    flush_busy = pend || state == FLUSH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= 1'b0;
      fidx     <= '0;
      b_addr   <= '0;
      rv       <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      state <= state_n;
      pend  <= (state_n == FLUSH && state != FLUSH) ? 1'b0 : pend | (flush && state != IDLE);
      fidx  <= state == FLUSH ? fidx + IDX'(1) : '0;
      if (f_vld) begin
        hit_cnt   <= hit_cnt + 32'd1;
        plru[idx] <= plru_touch(plru[idx], hw);
      end
      if (state == IDLE && state_n == REFILL) begin
        b_addr   <= f_pc & ~64'(LINE_BYTES - 1);
        rv       <= vic;
        miss_cnt <= miss_cnt + 32'd1;
      end
      if (state == REFILL && b_dv) begin
        valid[ridx][rv] <= 1'b1;
        plru[ridx]      <= plru_touch(plru[ridx], rv);
      end
      if (state == FLUSH) begin
        valid[fidx] <= '0;
        plru[fidx]  <= '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == REFILL && b_dv) begin
      data[ridx][rv] <= b_data;
      tags[ridx][rv] <= rtag;
    end
  end
endmodule

// File: tb/tb_icache_l1.sv
// tb_icache_l1: directed table, corner sequences and model-checked random traffic over three geometries
module tb_icache_l1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3], req [3], vld [3], fl [3], busy [3], brd [3], dv [3];
  logic [63:0] pc [3], baddr [3];
  logic [31:0] ir [3], hc [3], mc [3];
  logic [511:0] bd [3];
  int passes = 0, checks = 0;
  int sets_c [3] = '{64, 16, 64};
  int ways_c [3] = '{4, 1, 8};
  int lb_c [3] = '{32, 4, 64};
  logic [63:0] mline [3][64][8];
  bit mv [3][64][8];
  int mp [3][64];
  int mh [3], mm [3];
  typedef struct {logic [63:0] pc; bit hit;} vec_t;
  vec_t tbl [14];
  icache_l1 #(.SETS(64), .WAYS(4), .LINE_BYTES(32)) u0 (
    .clk(clk), .rst(rst[0]), .f_pc(pc[0]), .f_req(req[0]), .f_ir(ir[0]), .f_vld(vld[0]),
    .flush(fl[0]), .flush_busy(busy[0]), .b_addr(baddr[0]), .b_rd(brd[0]), .b_data(bd[0][255:0]),
    .b_dv(dv[0]), .hit_cnt(hc[0]), .miss_cnt(mc[0]));
  icache_l1 #(.SETS(16), .WAYS(1), .LINE_BYTES(4)) u1 (
    .clk(clk), .rst(rst[1]), .f_pc(pc[1]), .f_req(req[1]), .f_ir(ir[1]), .f_vld(vld[1]),
    .flush(fl[1]), .flush_busy(busy[1]), .b_addr(baddr[1]), .b_rd(brd[1]), .b_data(bd[1][31:0]),
    .b_dv(dv[1]), .hit_cnt(hc[1]), .miss_cnt(mc[1]));
  icache_l1 #(.SETS(64), .WAYS(8), .LINE_BYTES(64)) u2 (
    .clk(clk), .rst(rst[2]), .f_pc(pc[2]), .f_req(req[2]), .f_ir(ir[2]), .f_vld(vld[2]),
    .flush(fl[2]), .flush_busy(busy[2]), .b_addr(baddr[2]), .b_rd(brd[2]), .b_data(bd[2]),
    .b_dv(dv[2]), .hit_cnt(hc[2]), .miss_cnt(mc[2]));
  function automatic logic [31:0] wd(input logic [63:0] a);
    return a[31:0] * 32'h9E3779B1 ^ a[47:16] ^ 32'h00000013;
  endfunction
  function automatic logic [511:0] mkline(input int i, input logic [63:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < lb_c[i] / 4; k++) l[k*32 +: 32] = wd(base + 64'(4 * k));
    return l;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask
  function automatic int mset(input int i, input logic [63:0] a);
    return int'((a / 64'(lb_c[i])) % 64'(sets_c[i]));
  endfunction
  function automatic int mfind(input int i, input logic [63:0] a);
    int s;
    s = mset(i, a);
    for (int w = 0; w < ways_c[i]; w++)
      if (mv[i][s][w] && mline[i][s][w] == a / 64'(lb_c[i])) return w;
    return -1;
  endfunction
  function automatic int mvictim(input int i, input int s);
    int n;
    for (int w = 0; w < ways_c[i]; w++) if (!mv[i][s][w]) return w;
    n = 0;
    while (n < ways_c[i] - 1) n = 2 * n + 1 + ((mp[i][s] >> n) & 1);
    return n - (ways_c[i] - 1);
  endfunction
  function automatic void mtouch(input int i, input int s, input int w);
    int lo, hi, n, mid;
    lo = 0;
    hi = ways_c[i];
    n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin
        mp[i][s] |= 1 << n;
        n = 2 * n + 1;
        hi = mid;
      end else begin
        mp[i][s] &= ~(1 << n);
        n = 2 * n + 2;
        lo = mid;
      end
    end
  endfunction
  function automatic void mclear(input int i);
    for (int s = 0; s < 64; s++) begin
      mp[i][s] = 0;
      for (int w = 0; w < 8; w++) mv[i][s][w] = 1'b0;
    end
  endfunction
  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    req[i] = 1'b0;
    fl[i] = 1'b0;
    dv[i] = 1'b0;
    bd[i] = '0;
    pc[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst[i] = 1'b0;
    mclear(i);
    mh[i] = 0;
    mm[i] = 0;
  endtask
  task automatic fetch(input int i, input logic [63:0] a, input bit eh, input int dly);
    logic [63:0] la;
    int s, w;
    la = a & ~64'(lb_c[i] - 1);
    pc[i] = a;
    req[i] = 1'b1;
    @(negedge clk);
    chk($sformatf("vld[%0d]@%0h", i, a), vld[i], eh);
    if (eh) chk($sformatf("ir[%0d]@%0h", i, a), ir[i], wd(a));
    @(posedge clk);
    #1 req[i] = 1'b0;
    chk($sformatf("b_rd[%0d]@%0h", i, a), brd[i], !eh);
    if (!eh) begin
      chk($sformatf("b_addr[%0d]@%0h", i, a), baddr[i], la);
      repeat (dly) begin
        @(posedge clk);
        #1 chk($sformatf("b_addr_hold[%0d]", i), baddr[i], la);
      end
      dv[i] = 1'b1;
      bd[i] = mkline(i, la);
      @(posedge clk);
      #1 dv[i] = 1'b0;
      chk($sformatf("b_rd_drop[%0d]", i), brd[i], 0);
    end
    s = mset(i, a);
    w = mfind(i, a);
    if (w < 0) begin
      w = mvictim(i, s);
      mv[i][s][w] = 1'b1;
      mline[i][s][w] = la / 64'(lb_c[i]);
    end
    mtouch(i, s, w);
    if (eh) mh[i]++;
    else mm[i]++;
  endtask
  task automatic wait_flush(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("flush_cycles[%0d]", i), 64'(n), 64'(sets_c[i]));
  endtask
  initial begin
    logic [63:0] a;
    int tsel, isel;
    tbl = '{'{64'h0000, 0}, '{64'h0800, 0}, '{64'h1000, 0}, '{64'h1800, 0}, '{64'h0000, 1},
            '{64'h1000, 1}, '{64'h2000, 0}, '{64'h0800, 0}, '{64'h0004, 1}, '{64'h1800, 0},
            '{64'h1000, 0}, '{64'h081c, 1}, '{64'h2000, 0}, '{64'h0000, 0}};
    for (int i = 0; i < 3; i++) do_reset(i);
    chk("rst_vld", vld[0], 0);
    chk("rst_b_rd", brd[0], 0);
    chk("rst_b_addr", baddr[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_hit_cnt", hc[0], 0);
    chk("rst_miss_cnt", mc[0], 0);
    pc[0] = 64'h1000;
    req[0] = 1'b1;
    @(negedge clk);
    chk("first_vld", vld[0], 0);
    @(posedge clk);
    #1 chk("first_b_rd", brd[0], 1);
    chk("first_b_addr", baddr[0], 64'h1000);
    dv[0] = 1'b1;
    bd[0] = mkline(0, 64'h1000);
    bd[0][31:0] = 32'h00000013;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    @(negedge clk);
    chk("first_hit_vld", vld[0], 1);
    chk("first_hit_ir", ir[0], 32'h00000013);
    @(posedge clk);
    #1 req[0] = 1'b0;
    chk("first_miss_cnt", mc[0], 1);
    chk("first_hit_cnt", hc[0], 1);
    do_reset(0);
    for (int k = 0; k < 14; k++) fetch(0, tbl[k].pc, tbl[k].hit, k % 3);
    chk("tbl_hit_cnt", hc[0], 4);
    chk("tbl_miss_cnt", mc[0], 10);
    do_reset(0);
    pc[0] = 64'h3000;
    req[0] = 1'b1;
    @(negedge clk);
    chk("stall_miss", vld[0], 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      pc[0] = {32'($urandom), 32'($urandom)} & ~64'h3;
      @(negedge clk);
      chk("stall_b_addr", baddr[0], 64'h3000);
      chk("stall_vld", vld[0], 0);
      chk("stall_b_rd", brd[0], 1);
      @(posedge clk);
      #1;
    end
    dv[0] = 1'b1;
    bd[0] = mkline(0, 64'h3000);
    pc[0] = 64'h3008;
    @(posedge clk);
    #1 dv[0] = 1'b0;
    @(negedge clk);
    chk("stall_land_vld", vld[0], 1);
    chk("stall_land_ir", ir[0], wd(64'h3008));
    @(posedge clk);
    #1 req[0] = 1'b0;
    do_reset(0);
    fetch(0, 64'h0000, 0, 0);
    pc[0] = 64'h4000;
    req[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req[0] = 1'b0;
    fl[0] = 1'b1;
    @(posedge clk);
    #1 fl[0] = 1'b0;
    chk("pend_busy", busy[0], 1);
    chk("pend_b_rd", brd[0], 1);
    dv[0] = 1'b1;
    bd[0] = mkline(0, 64'h4000);
    @(posedge clk);
    #1 dv[0] = 1'b0;
    wait_flush(0);
    mclear(0);
    fetch(0, 64'h0000, 0, 1);
    fetch(0, 64'h4000, 0, 0);
    do_reset(0);
    fetch(0, 64'h0000, 0, 0);
    pc[0] = 64'h5000;
    req[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req[0] = 1'b0;
    chk("abort_b_rd_up", brd[0], 1);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    dv[0] = 1'b1;
    bd[0] = mkline(0, 64'h5000);
    @(posedge clk);
    #1 dv[0] = 1'b0;
    chk("abort_b_rd", brd[0], 0);
    chk("abort_hit_cnt", hc[0], 0);
    chk("abort_miss_cnt", mc[0], 0);
    mclear(0);
    fetch(0, 64'h0000, 0, 0);
    fetch(0, 64'h5000, 0, 0);
    chk("abort_refetch_miss_cnt", mc[0], 2);
    for (int i = 0; i < 3; i++) begin
      do_reset(i);
      for (int n = 0; n < 250; n++) begin
        case ($urandom_range(0, 24))
          0: begin
            fl[i] = 1'b1;
            @(posedge clk);
            #1 fl[i] = 1'b0;
            wait_flush(i);
            mclear(i);
          end
          1: begin
            dv[i] = 1'b1;
            for (int k = 0; k < 16; k++) bd[i][k*32 +: 32] = $urandom;
            @(posedge clk);
            #1 dv[i] = 1'b0;
          end
          default: begin
            tsel = $urandom_range(0, ways_c[i] + 1);
            isel = $urandom_range(0, 2);
            a = 64'((tsel * sets_c[i] + isel) * lb_c[i] + 4 * $urandom_range(0, lb_c[i] / 4 - 1));
            if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
            fetch(i, a, mfind(i, a) >= 0, $urandom_range(0, 3));
          end
        endcase
      end
      chk($sformatf("rnd_hit_cnt[%0d]", i), hc[i], 64'(mh[i]));
      chk($sformatf("rnd_miss_cnt[%0d]", i), mc[i], 64'(mm[i]));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
